// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU issue scheduler: instruction field
// offsets, the scheduler FSM states and the writeback scoreboard entry.
package alu_sched_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int REG_W   = 5;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  // Wide enough for any sensible requester count; narrowed at the use site.
  localparam int SB_ID_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } sched_state_t;

  typedef struct packed {
    logic               v;
    logic [REG_W-1:0]   rd;
    logic [SB_ID_W-1:0] id;
  } sb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Mask-based round-robin arbiter: picks the first requester after 'last',
// wrapping around to the lowest index when none sits above it.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic [NREQ-1:0] win,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] pick;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      mask[i] = (i > int'(last));
    end
    masked = req & mask;
    pick   = (|masked) ? masked : req;
    win    = '0;
    idx    = '0;
    // Walk downwards so the lowest set bit is the one left standing.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        win    = '0;
        win[i] = 1'b1;
        idx    = ID_W'(i);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Round-robin issue scheduler in front of the register-file/ALU datapath, with
// RAW-hazard stalls against in-flight writebacks. ISSUE_PERF_CNT_EN adds counters.
module alu_issue_scheduler
  import alu_sched_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 2,
  parameter  int LAT   = 2,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_instr,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      dp_addr,
  output logic                  dp_valid,
  output logic [ID_W-1:0]       dp_id,
  output logic                  retire_valid,
  output logic [ID_W-1:0]       retire_id,
  output logic                  busy,
  output logic                  stall
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]           issue_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  sched_state_t     state;
  logic [ID_W-1:0]  last_ptr;
  logic [NREQ-1:0]  win_onehot;
  logic [ID_W-1:0]  win_idx;
  logic             win_any;
  logic [WIDTH-1:0] win_instr;
  logic [REG_W-1:0] win_rs1;
  logic [REG_W-1:0] win_rs2;
  logic             hazard;
  logic             sb_busy;
  logic             grant_ok;
  logic             grant;
  sb_entry_t        new_entry;
  sb_entry_t        sb [LAT];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (req_valid),
    .last (last_ptr),
    .win  (win_onehot),
    .idx  (win_idx),
    .any  (win_any)
  );

  // Both source fields are checked for every opcode; rd=x0 never blocks.
  always_comb begin
    win_instr = req_instr[int'(win_idx)*WIDTH +: WIDTH];
    win_rs1   = win_instr[RS1_LSB +: REG_W];
    win_rs2   = win_instr[RS2_LSB +: REG_W];
    hazard    = 1'b0;
    sb_busy   = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (sb[i].v) begin
        sb_busy = 1'b1;
        if (sb[i].rd != '0 && (sb[i].rd == win_rs1 || sb[i].rd == win_rs2)) begin
          hazard = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_ok  = (state != DRAIN) && !flush && win_any;
    grant     = grant_ok && !hazard;
    stall     = grant_ok && hazard;
    req_ready = grant ? win_onehot : '0;
    busy      = sb_busy || (state != IDLE);
    new_entry = '0;
    if (grant) begin
      new_entry.v  = 1'b1;
      new_entry.rd = win_instr[RD_LSB +: REG_W];
      new_entry.id = SB_ID_W'(win_idx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (flush) state <= DRAIN;
                 else if (|req_valid) state <= ISSUE;
        ISSUE:   if (flush) state <= DRAIN;
                 else if (!(|req_valid)) state <= IDLE;
        DRAIN:   if (!flush && !sb_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Issue register; the pointer only moves on an actual grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_addr  <= WIDTH'(NOP_INSTR);
      dp_valid <= 1'b0;
      dp_id    <= '0;
      last_ptr <= ID_W'(NREQ - 1);
    end else if (grant) begin
      dp_addr  <= win_instr;
      dp_valid <= 1'b1;
      dp_id    <= win_idx;
      last_ptr <= win_idx;
    end else begin
      dp_addr  <= WIDTH'(NOP_INSTR);
      dp_valid <= 1'b0;
    end
  end

  // Writeback shift register; an entry stops blocking on the edge it retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        sb[i] <= '0;
      end
      retire_valid <= 1'b0;
      retire_id    <= '0;
    end else begin
      sb[0] <= new_entry;
      for (int i = 1; i < LAT; i++) begin
        sb[i] <= sb[i-1];
      end
      retire_valid <= sb[LAT-1].v;
      retire_id    <= ID_W'(sb[LAT-1].id);
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (grant) issue_cnt <= issue_cnt + 32'd1;
      if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
